// File: rtl/onehot_seq_checked_pkg.sv
// rtl/onehot_seq_checked_pkg.sv - shared types and one-hot helpers for the ring sequencer
package onehot_seq_pkg;

  localparam int MAX_STATES = 32;
  typedef logic [MAX_STATES-1:0] vec_t;

  typedef enum logic [2:0] {
    SRC_FORCE,
    SRC_RECOVER,
    SRC_LOAD,
    SRC_STEP,
    SRC_HOLD
  } nxt_src_e;

  function automatic int calc_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Narrower vectors are zero-extended by the caller; padding never changes one-hotness.
  function automatic logic is_onehot(input vec_t v);
    return (v != '0) && ((v & (v - vec_t'(1))) == '0);
  endfunction

  function automatic logic [4:0] onehot2idx(input vec_t v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_STATES; i++) begin
      if (v[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

  function automatic vec_t idx2onehot(input logic [4:0] idx);
    return vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/onehot_seq_checked_if.sv
// rtl/onehot_seq_checked_if.sv - control and status bundle of the one-hot ring sequencer
interface onehot_seq_checked_if #(
  parameter int NUM_STATES = 4,
  parameter int ERR_CNT_W  = 8
);
  import onehot_seq_pkg::*;

  localparam int IDX_W = calc_idx_w(NUM_STATES);

  logic                  en;
  logic                  dir;
  logic                  load;
  logic [IDX_W-1:0]      load_idx;
  logic                  force_vld;
  logic [NUM_STATES-1:0] force_vec;
  logic                  clr_err;
  logic [NUM_STATES-1:0] state;
  logic [IDX_W-1:0]      state_idx;
  logic                  wrap;
  logic                  err;
  logic                  err_sticky;
  logic [ERR_CNT_W-1:0]  err_cnt;

  modport master (
    output en, dir, load, load_idx, force_vld, force_vec, clr_err,
    input  state, state_idx, wrap, err, err_sticky, err_cnt
  );

  modport slave (
    input  en, dir, load, load_idx, force_vld, force_vec, clr_err,
    output state, state_idx, wrap, err, err_sticky, err_cnt
  );

endinterface

// File: rtl/onehot_seq_checked_legality_chk.sv
// rtl/onehot_seq_checked_legality_chk.sv - one-hot legality flag with sticky bit and saturating count
module onehot_legality_chk
  import onehot_seq_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [W-1:0]     vec,
  input  logic             clr_err,
  input  logic             set_sticky,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  assign err = !is_onehot(vec_t'(vec));

  // A new error on the same edge as clr_err wins: sticky stays set, count restarts at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (err || set_sticky) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end

      if (err) begin
        if (clr_err) begin
          err_cnt <= CNT_W'(1);
        end else if (err_cnt != '1) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end else if (clr_err) begin
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/onehot_seq_checked.sv
// rtl/onehot_seq_checked.sv - parametrised one-hot ring sequencer with legality check and self-recovery
module onehot_seq_checked
  import onehot_seq_pkg::*;
#(
  parameter int NUM_STATES = 4,
  parameter int RESET_IDX  = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  onehot_seq_checked_if.slave  bus
);

  localparam int                    IDX_W     = calc_idx_w(NUM_STATES);
  localparam logic [NUM_STATES-1:0] RESET_VEC = NUM_STATES'(1) << RESET_IDX;
  localparam logic [IDX_W:0]        NS_LIMIT  = (IDX_W+1)'(NUM_STATES);

  logic [NUM_STATES-1:0] state_q;
  logic                  wrap_q;
  logic                  err;
  logic                  err_sticky;
  logic [ERR_CNT_W-1:0]  err_cnt;
  logic                  load_bad;
  logic                  bad_load_set;
  nxt_src_e              src;

  assign load_bad     = {1'b0, bus.load_idx} >= NS_LIMIT;
  assign bad_load_set = (src == SRC_LOAD) && load_bad;

  always_comb begin
    src = SRC_HOLD;
    if (bus.force_vld)  src = SRC_FORCE;
    else if (err)       src = SRC_RECOVER;
    else if (bus.load)  src = SRC_LOAD;
    else if (bus.en)    src = SRC_STEP;
  end

  // Only an en-driven rotation can raise wrap; it reports the boundary bit that just rotated out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_VEC;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (src)
        SRC_FORCE:   state_q <= bus.force_vec;
        SRC_RECOVER: state_q <= RESET_VEC;
        SRC_LOAD:    state_q <= load_bad ? RESET_VEC
                                         : NUM_STATES'(idx2onehot(5'(bus.load_idx)));
        SRC_STEP: begin
          if (bus.dir) begin
            state_q <= {state_q[0], state_q[NUM_STATES-1:1]};
            wrap_q  <= state_q[0];
          end else begin
            state_q <= {state_q[NUM_STATES-2:0], state_q[NUM_STATES-1]};
            wrap_q  <= state_q[NUM_STATES-1];
          end
        end
        default:     state_q <= state_q;
      endcase
    end
  end

  onehot_legality_chk #(
    .W     (NUM_STATES),
    .CNT_W (ERR_CNT_W)
  ) u_chk (
    .clk        (clk),
    .reset_n    (reset_n),
    .vec        (state_q),
    .clr_err    (bus.clr_err),
    .set_sticky (bad_load_set),
    .err        (err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  assign bus.state      = state_q;
  assign bus.state_idx  = err ? '0 : IDX_W'(onehot2idx(vec_t'(state_q)));
  assign bus.wrap       = wrap_q;
  assign bus.err        = err;
  assign bus.err_sticky = err_sticky;
  assign bus.err_cnt    = err_cnt;

endmodule

// File: tb/tb_onehot_seq_checked.sv
// tb/tb_onehot_seq_checked.sv - self-checking bench for the one-hot ring sequencer and its checker
module tb_onehot_seq_checked;

  logic clk;
  logic reset_n;

  onehot_seq_checked_if #(.NUM_STATES(4), .ERR_CNT_W(8)) b4 ();
  onehot_seq_checked_if #(.NUM_STATES(8), .ERR_CNT_W(8)) b8 ();
  onehot_seq_checked_if #(.NUM_STATES(5), .ERR_CNT_W(8)) b5 ();

  onehot_seq_checked #(.NUM_STATES(4), .RESET_IDX(0), .ERR_CNT_W(8))
    dut4 (.clk(clk), .reset_n(reset_n), .bus(b4.slave));
  onehot_seq_checked #(.NUM_STATES(8), .RESET_IDX(0), .ERR_CNT_W(8))
    dut8 (.clk(clk), .reset_n(reset_n), .bus(b8.slave));
  onehot_seq_checked #(.NUM_STATES(5), .RESET_IDX(0), .ERR_CNT_W(8))
    dut5 (.clk(clk), .reset_n(reset_n), .bus(b5.slave));

  logic [5:0] cv;
  logic       cclr;
  logic       cerr;
  logic       cst;
  logic [2:0] ccnt;

  onehot_legality_chk #(.W(6), .CNT_W(3)) u_chk6 (
    .clk(clk), .reset_n(reset_n), .vec(cv), .clr_err(cclr), .set_sticky(1'b0),
    .err(cerr), .err_sticky(cst), .err_cnt(ccnt)
  );

  always #5 clk = ~clk;

  a_recover: assert property (@(posedge clk) disable iff (!reset_n)
    (b4.err && !b4.force_vld) |=> !b4.err)
    else $error("FAIL assert_recover: state not one-hot after recovery");

  a_wrap: assert property (@(posedge clk) disable iff (!reset_n)
    b4.wrap |-> ($past(b4.state) == 4'b0001 || $past(b4.state) == 4'b1000))
    else $error("FAIL assert_wrap: wrap without boundary state");

  int n_pass;
  int n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       en, dir, load;
    logic [1:0] li;
    logic       fv;
    logic [3:0] fvec;
    logic       clr;
    logic [3:0] e_state;
    logic [1:0] e_idx;
    logic       e_wrap, e_err, e_st;
    logic [7:0] e_cnt;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(input logic en, dir, load, input logic [1:0] li,
                              input logic fv, input logic [3:0] fvec, input logic clr,
                              input logic [3:0] es, input logic [1:0] ei,
                              input logic ew, ee, est, input logic [7:0] ec);
    row_t r;
    r.en = en; r.dir = dir; r.load = load; r.li = li; r.fv = fv; r.fvec = fvec; r.clr = clr;
    r.e_state = es; r.e_idx = ei; r.e_wrap = ew; r.e_err = ee; r.e_st = est; r.e_cnt = ec;
    return r;
  endfunction

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic drive4(input logic en, dir, load, input logic [1:0] li,
                        input logic fv, input logic [3:0] fvec, input logic clr);
    b4.en = en; b4.dir = dir; b4.load = load; b4.load_idx = li;
    b4.force_vld = fv; b4.force_vec = fvec; b4.clr_err = clr;
  endtask

  logic [3:0] m_vec;
  logic       m_wrap, m_st, m_err_now;
  int         m_cnt, cur, nxt;
  logic       c_st;
  int         c_cnt;

  initial begin
    clk = 0; reset_n = 0; n_pass = 0; n_total = 0;
    cv = 6'b000001; cclr = 0;
    drive4(0, 0, 0, 0, 0, 0, 0);
    b8.en = 0; b8.dir = 0; b8.load = 0; b8.load_idx = 0; b8.force_vld = 0; b8.force_vec = 0; b8.clr_err = 0;
    b5.en = 0; b5.dir = 0; b5.load = 0; b5.load_idx = 0; b5.force_vld = 0; b5.force_vec = 0; b5.clr_err = 0;

    // row: en dir load li fv fvec clr | state idx wrap err sticky cnt
    tbl.push_back(mk(1, 0, 0, 0, 0, 4'h0, 0, 4'b0010, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4'h0, 0, 4'b0100, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4'h0, 0, 4'b1000, 3, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4'h0, 0, 4'b0001, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4'h0, 0, 4'b0010, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'h0, 0, 4'b0001, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'h0, 0, 4'b1000, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 4'h6, 0, 4'b0110, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 4'b0001, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 1, 4'b0001, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 2, 0, 4'h0, 0, 4'b0100, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 4'h3, 0, 4'b0011, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 4'h8, 0, 4'b1000, 3, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 0, 4'b0001, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 4'h0, 1, 4'b0000, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4'h0, 1, 4'b0001, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4'h0, 0, 4'b0010, 1, 0, 0, 1, 1));

    repeat (2) @(negedge clk);
    reset_n = 1;
    chk("rst_state", b4.state, 4'b0001);
    chk("rst_idx", b4.state_idx, 0);
    chk("rst_wrap", b4.wrap, 0);
    chk("rst_err", b4.err, 0);
    chk("rst_sticky", b4.err_sticky, 0);
    chk("rst_cnt", b4.err_cnt, 0);

    // Eight-state reverse wrap then load; five-state out-of-range load.
    chk("n8_idx0", b8.state_idx, 0);
    b8.en = 1; b8.dir = 1;
    b5.load = 1; b5.load_idx = 6;
    @(negedge clk);
    chk("n8_rev_state", b8.state, 8'h80);
    chk("n8_rev_idx", b8.state_idx, 7);
    chk("n8_rev_wrap", b8.wrap, 1);
    chk("n5_oor_state", b5.state, 5'b00001);
    chk("n5_oor_sticky", b5.err_sticky, 1);
    chk("n5_oor_cnt", b5.err_cnt, 0);
    chk("n5_oor_err", b5.err, 0);
    b8.en = 0; b8.load = 1; b8.load_idx = 5;
    b5.load = 0; b5.clr_err = 1;
    @(negedge clk);
    chk("n8_load_state", b8.state, 8'h20);
    chk("n8_load_idx", b8.state_idx, 5);
    chk("n8_load_wrap", b8.wrap, 0);
    chk("n5_clr_sticky", b5.err_sticky, 0);
    b8.load = 0;
    b5.load = 1; b5.load_idx = 7;
    @(negedge clk);
    chk("n5_oor_clr_sticky", b5.err_sticky, 1);
    b5.load = 0; b5.clr_err = 0;

    foreach (tbl[i]) begin
      drive4(tbl[i].en, tbl[i].dir, tbl[i].load, tbl[i].li, tbl[i].fv, tbl[i].fvec, tbl[i].clr);
      @(negedge clk);
      chk($sformatf("tbl%0d_state", i), b4.state, tbl[i].e_state);
      chk($sformatf("tbl%0d_idx", i), b4.state_idx, tbl[i].e_idx);
      chk($sformatf("tbl%0d_wrap", i), b4.wrap, tbl[i].e_wrap);
      chk($sformatf("tbl%0d_err", i), b4.err, tbl[i].e_err);
      chk($sformatf("tbl%0d_sticky", i), b4.err_sticky, tbl[i].e_st);
      chk($sformatf("tbl%0d_cnt", i), b4.err_cnt, tbl[i].e_cnt);
    end

    // Counter saturation under a held all-zero force, then clear while still in error.
    drive4(0, 0, 0, 0, 1, 4'h0, 0);
    repeat (300) @(negedge clk);
    chk("sat_cnt", b4.err_cnt, 255);
    chk("sat_sticky", b4.err_sticky, 1);
    chk("sat_err", b4.err, 1);
    b4.clr_err = 1;
    @(negedge clk);
    chk("sat_clr_cnt", b4.err_cnt, 1);
    chk("sat_clr_sticky", b4.err_sticky, 1);
    drive4(0, 0, 0, 0, 0, 4'h0, 0);
    @(negedge clk);
    chk("sat_rec_state", b4.state, 4'b0001);
    chk("sat_rec_err", b4.err, 0);
    chk("sat_rec_cnt", b4.err_cnt, 2);

    // Asynchronous reset between edges, right after a reverse wrap.
    drive4(1, 1, 0, 0, 0, 4'h0, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_wrap", b4.wrap, 1);
    #1;
    reset_n = 0;
    #1;
    chk("arst_state", b4.state, 4'b0001);
    chk("arst_wrap", b4.wrap, 0);
    chk("arst_cnt", b4.err_cnt, 0);
    chk("arst_sticky", b4.err_sticky, 0);
    @(negedge clk);
    b4.en = 0;
    reset_n = 1;
    @(negedge clk);
    chk("rel_hold_state", b4.state, 4'b0001);
    drive4(1, 0, 0, 0, 0, 4'h0, 0);
    @(negedge clk);
    chk("rel_step_state", b4.state, 4'b0010);

    // Randomised run against an index-level reference model.
    m_vec = 4'b0010; m_wrap = 0; m_st = 0; m_cnt = 0;
    c_st = 0; c_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      chk("rnd_state", b4.state, m_vec);
      chk("rnd_wrap", b4.wrap, m_wrap);
      chk("rnd_err", b4.err, $countones(m_vec) != 1);
      chk("rnd_idx", b4.state_idx, ($countones(m_vec) == 1) ? idx_of(m_vec) : 0);
      chk("rnd_sticky", b4.err_sticky, m_st);
      chk("rnd_cnt", b4.err_cnt, m_cnt);
      chk("c6_err", cerr, $countones(cv) != 1);
      chk("c6_sticky", cst, c_st);
      chk("c6_cnt", ccnt, c_cnt);

      drive4(1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0, 2'($urandom),
             $urandom_range(0, 9) == 0, 4'($urandom), $urandom_range(0, 7) == 0);
      m_err_now = ($countones(m_vec) != 1);
      cur = idx_of(m_vec);
      m_wrap = 0;
      if (b4.force_vld) m_vec = b4.force_vec;
      else if (m_err_now) m_vec = 4'b0001;
      else if (b4.load) m_vec = 4'b0001 << b4.load_idx;
      else if (b4.en) begin
        nxt = b4.dir ? (cur + 3) % 4 : (cur + 1) % 4;
        m_wrap = b4.dir ? (cur == 0) : (cur == 3);
        m_vec = 4'b0001 << nxt;
      end
      if (m_err_now) begin
        m_st = 1;
        m_cnt = b4.clr_err ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (b4.clr_err) begin
        m_st = 0;
        m_cnt = 0;
      end

      cv = ($urandom_range(0, 1) == 0) ? (6'b000001 << $urandom_range(0, 5)) : 6'($urandom);
      cclr = ($urandom_range(0, 9) == 0);
      if ($countones(cv) != 1) begin
        c_st = 1;
        c_cnt = cclr ? 1 : ((c_cnt < 7) ? c_cnt + 1 : 7);
      end else if (cclr) begin
        c_st = 0;
        c_cnt = 0;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
